// File: rtl/frame_addr_decoder_fifo.sv
// Frame address decoder with a DEPTH-entry FIFO, range check and overflow reporting.
// Splits each frame into address/data and presents entries under a valid/ack handshake.
module frame_addr_decoder_fifo #(
    parameter int ADDR_W     = 4,
    parameter int DATA_W     = 4,
    parameter int DEPTH      = 4,
    parameter int ADDR_LIMIT = 2 ** ADDR_W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [ADDR_W+DATA_W-1:0]   frame,
    input  logic                       frame_valid,
    input  logic                       ack,
    output logic [ADDR_W-1:0]          address,
    output logic [DATA_W-1:0]          data,
    output logic                       valid,
    output logic                       addr_err,
    output logic                       overflow,
    output logic [$clog2(DEPTH+1)-1:0] fifo_count
);

    localparam int FRAME_W = ADDR_W + DATA_W;
    localparam int PTR_W   = $clog2(DEPTH);
    localparam int CNT_W   = $clog2(DEPTH + 1);
    localparam logic [ADDR_W:0] LIMIT = (ADDR_W + 1)'(ADDR_LIMIT);

    logic                 fv_q;
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic [FRAME_W-1:0]   mem_q [DEPTH];
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic [DATA_W-1:0]    data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 addr_err_q, addr_err_d;
    logic                 overflow_q, overflow_d;

    logic accept, in_range, full, pop, push;

    // The output register is refilled from the FIFO head; a fresh write is never bypassed.
    always_comb begin
        accept     = frame_valid && !fv_q;
        in_range   = {1'b0, frame[FRAME_W-1:DATA_W]} < LIMIT;
        full       = (count_q == CNT_W'(DEPTH));
        pop        = (!valid_q || ack) && (count_q != '0);
        push       = accept && in_range && (!full || pop);
        addr_err_d = accept && !in_range;
        overflow_d = accept && in_range && full && !pop;

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        addr_d   = addr_q;
        data_d   = data_q;
        valid_d  = valid_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
            addr_d   = mem_q[rd_ptr_q][FRAME_W-1:DATA_W];
            data_d   = mem_q[rd_ptr_q][DATA_W-1:0];
            valid_d  = 1'b1;
        end else if (ack) begin
            valid_d = 1'b0;
        end

        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !push) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= frame;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fv_q       <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            addr_q     <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            addr_err_q <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            fv_q       <= frame_valid;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            addr_err_q <= addr_err_d;
            overflow_q <= overflow_d;
        end
    end

    assign address    = addr_q;
    assign data       = data_q;
    assign valid      = valid_q;
    assign addr_err   = addr_err_q;
    assign overflow   = overflow_q;
    assign fifo_count = count_q;

endmodule

// File: tb/tb_frame_addr_decoder_fifo.sv
// Bench for frame_addr_decoder_fifo: directed scenarios followed by random traffic,
// checked against a queue-based reference model and a scoreboard of accepted frames.
module tb_frame_addr_decoder_fifo;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 4;
    localparam int DEPTH  = 4;
    localparam int LIMIT  = 10;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] frame;
    logic       frame_valid;
    logic       ack;
    logic [3:0] address;
    logic [3:0] data;
    logic       valid;
    logic       addr_err;
    logic       overflow;
    logic [2:0] fifo_count;

    int nChecks = 0;
    int nFail   = 0;
    bit checking = 1'b0;

    logic [7:0] expQ[$];
    bit  outValid;
    int  fifoCnt;
    bit  expErr;
    bit  expOvf;
    bit  prevFv;

    frame_addr_decoder_fifo #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_LIMIT(LIMIT)
    ) dut (
        .clk(clk), .rst(rst), .frame(frame), .frame_valid(frame_valid), .ack(ack),
        .address(address), .data(data), .valid(valid), .addr_err(addr_err),
        .overflow(overflow), .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int act, input int exp);
        nChecks++;
        if (act != exp) begin
            nFail++;
            $display("[TB] FAIL %s: actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: occupancy counts and a list of frames that reached the buffer.
    always @(posedge clk) begin
        bit edgeSeen, loadOut, doWrite;
        if (rst) begin
            outValid = 1'b0;
            fifoCnt  = 0;
            expErr   = 1'b0;
            expOvf   = 1'b0;
            prevFv   = 1'b0;
            expQ.delete();
        end else begin
            edgeSeen = frame_valid && !prevFv;
            loadOut  = (!outValid || ack) && (fifoCnt > 0);
            expErr   = 1'b0;
            expOvf   = 1'b0;
            doWrite  = 1'b0;
            if (edgeSeen) begin
                if (int'(frame[7:4]) >= LIMIT) expErr = 1'b1;
                else if (fifoCnt < DEPTH || loadOut) doWrite = 1'b1;
                else expOvf = 1'b1;
            end
            if (loadOut) begin
                outValid = 1'b1;
                fifoCnt  = fifoCnt - 1;
            end else if (ack) begin
                outValid = 1'b0;
            end
            if (doWrite) begin
                fifoCnt = fifoCnt + 1;
                expQ.push_back(frame);
            end
            prevFv = frame_valid;
        end
    end

    // Monitor: status every cycle, and payload whenever an entry is handed over.
    always @(negedge clk) begin
        logic [7:0] head;
        if (checking) begin
            checkOutput("valid", int'(valid), int'(outValid));
            checkOutput("fifo_count", int'(fifo_count), fifoCnt);
            checkOutput("addr_err", int'(addr_err), int'(expErr));
            checkOutput("overflow", int'(overflow), int'(expOvf));
            if (valid && ack && !rst) begin
                if (expQ.size() == 0) begin
                    checkOutput("scoreboard underrun", 1, 0);
                end else begin
                    head = expQ.pop_front();
                    checkOutput("address", int'(address), int'(head[7:4]));
                    checkOutput("data", int'(data), int'(head[3:0]));
                end
            end
        end
    end

    task automatic applyStimulus(input logic [7:0] f, input int hold, input logic a, input int gap);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #2;
            frame = f; frame_valid = 1'b1; ack = a;
        end
        for (int i = 0; i < gap; i++) begin
            @(posedge clk); #2;
            frame_valid = 1'b0; ack = a;
        end
    endtask

    task automatic doReset();
        @(posedge clk); #2;
        rst = 1'b1; frame_valid = 1'b0; ack = 1'b0;
        @(posedge clk); #2;
        rst = 1'b0;
    endtask

    task automatic checkNow(input string name, input int expValid, input int expAddr, input int expData, input int expCnt);
        @(negedge clk);
        checkOutput({name, " valid"}, int'(valid), expValid);
        checkOutput({name, " address"}, int'(address), expAddr);
        checkOutput({name, " data"}, int'(data), expData);
        checkOutput({name, " fifo_count"}, int'(fifo_count), expCnt);
    endtask

    initial begin
        rst = 1'b1; frame = '0; frame_valid = 1'b0; ack = 1'b0;
        @(posedge clk); @(posedge clk); #2;
        rst = 1'b0;
        checking = 1'b1;
        checkNow("reset", 0, 0, 0, 0);

        // Single two-cycle strobe, output held until acked
        applyStimulus(8'h92, 2, 1'b0, 2);
        checkNow("single", 1, 9, 2, 0);
        applyStimulus(8'h00, 0, 1'b0, 2);
        checkNow("held", 1, 9, 2, 0);
        applyStimulus(8'h00, 0, 1'b1, 2);

        // Long strobe gives one entry
        applyStimulus(8'h37, 5, 1'b0, 2);
        checkNow("long strobe", 1, 3, 7, 0);
        applyStimulus(8'h00, 0, 1'b1, 2);

        // Fill output plus FIFO, then overflow
        for (int i = 0; i < 5; i++) applyStimulus(8'h10 + 8'(i * 17), 1, 1'b0, 1);
        checkNow("full", 1, 1, 0, 4);
        applyStimulus(8'h66, 1, 1'b0, 2);
        checkNow("after overflow", 1, 1, 0, 4);

        // Push into a full FIFO while popping
        applyStimulus(8'h84, 1, 1'b1, 0);
        applyStimulus(8'h00, 0, 1'b0, 1);
        checkNow("push+pop full", 1, 2, 1, 4);

        // Drain in order
        applyStimulus(8'h00, 0, 1'b1, 8);
        checkNow("drained", 0, 8, 4, 0);

        // Out-of-range address rejected, then an in-range one
        applyStimulus(8'hA5, 1, 1'b1, 2);
        checkNow("addr reject", 0, 8, 4, 0);
        applyStimulus(8'h95, 1, 1'b0, 2);
        checkNow("addr accept", 1, 9, 5, 0);

        // Reset with entries pending
        for (int i = 0; i < 3; i++) applyStimulus(8'h20 + 8'(i), 1, 1'b0, 1);
        doReset();
        checkNow("mid reset", 0, 0, 0, 0);
        applyStimulus(8'h4C, 1, 1'b0, 2);
        checkNow("after reset", 1, 4, 12, 0);
        applyStimulus(8'h00, 0, 1'b1, 2);

        // Random traffic with varying consumer pressure and rare resets
        for (int i = 0; i < 2000; i++) begin
            @(posedge clk); #2;
            frame       = 8'($urandom);
            frame_valid = 1'($urandom_range(0, 1));
            ack         = (i % 400 < 200) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            rst         = ($urandom_range(0, 299) == 0);
        end
        @(posedge clk); #2;
        rst = 1'b0;
        applyStimulus(8'h00, 0, 1'b1, DEPTH + 4);
        @(negedge clk);
        checkOutput("scoreboard empty", expQ.size(), 0);
        checkOutput("final valid", int'(valid), 0);
        checking = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
